// File: rtl/traffic_input_conditioner_if.sv
// Signal bundle between the raw field inputs / controller and the input
// conditioner. The conditioner takes the slave side; whoever drives the raw
// inputs and walk_clear (board wiring, controller, testbench) takes master.
interface traffic_input_conditioner_if;
   logic sensor_raw;
   logic walk_raw;
   logic reprogram_raw;
   logic walk_clear;
   logic sensor;
   logic walkRequest;
   logic reprogram;

   modport master (
      output sensor_raw, walk_raw, reprogram_raw, walk_clear,
      input  sensor, walkRequest, reprogram
   );

   modport slave (
      input  sensor_raw, walk_raw, reprogram_raw, walk_clear,
      output sensor, walkRequest, reprogram
   );
endinterface

// File: rtl/traffic_input_conditioner.sv
// Traffic input conditioner: synchronizes and debounces the three asynchronous
// field inputs (side-street sensor, walk button, reprogram button) and turns
// them into the levels/pulses the traffic controller expects:
//   sensor      - debounced level of the sensor contact
//   walkRequest - sticky request, set by a debounced walk press, cleared by
//                 walk_clear (a simultaneous new press wins so no request is lost)
//   reprogram   - one-cycle pulse per debounced reprogram press
// There is no handshake here: outputs are plain levels/pulses sampled by the
// controller every cycle, and walk_clear is a one-cycle acknowledge.
module traffic_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4   // legal 1..255
) (
   input  logic                          clk,
   input  logic                          reset,
   traffic_input_conditioner_if.slave    tic
);

   localparam int unsigned NCH       = 3;
   localparam int unsigned CH_SENSOR = 0;
   localparam int unsigned CH_WALK   = 1;
   localparam int unsigned CH_REPROG = 2;

   // Counter value on which the next differing cycle commits the new level.
   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [NCH-1:0] raw;
   logic [NCH-1:0] sync1_d, sync1_q;
   logic [NCH-1:0] sync2_d, sync2_q;
   logic [NCH-1:0] clean_d, clean_q;
   logic [NCH-1:0] prev_d, prev_q;      // clean delayed one cycle, for edge detect
   logic [NCH-1:0] rise;
   logic [7:0]     cnt_d [NCH];
   logic [7:0]     cnt_q [NCH];
   logic           reprogram_d, reprogram_q;
   logic           walk_req_d, walk_req_q;

   assign raw = {tic.reprogram_raw, tic.walk_raw, tic.sensor_raw};

   // Next-state: synchronizer shift, per-channel debounce, edge detect, walk latch.
   always_comb begin
      sync1_d     = raw;
      sync2_d     = sync1_q;
      clean_d     = clean_q;
      prev_d      = clean_q;
      reprogram_d = 1'b0;
      walk_req_d  = walk_req_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = 8'd0;
         if (sync2_q[i] != clean_q[i]) begin
            // Commit on the cycle the count would reach DEBOUNCE_CYCLES, so the
            // counter itself never holds that value and cannot wrap.
            if (cnt_q[i] == DB_LAST) begin
               clean_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end

      rise        = clean_q & ~prev_q;
      reprogram_d = rise[CH_REPROG];

      // A new press in the same cycle as walk_clear keeps the request.
      if (rise[CH_WALK]) begin
         walk_req_d = 1'b1;
      end else if (tic.walk_clear) begin
         walk_req_d = 1'b0;
      end
   end

   // State register with synchronous reset; reset also drops partial counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         clean_q     <= '0;
         prev_q      <= '0;
         cnt_q       <= '{default: 8'd0};
         reprogram_q <= 1'b0;
         walk_req_q  <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         clean_q     <= clean_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         reprogram_q <= reprogram_d;
         walk_req_q  <= walk_req_d;
      end
   end

   assign tic.sensor      = clean_q[CH_SENSOR];
   assign tic.walkRequest = walk_req_q;
   assign tic.reprogram   = reprogram_q;

endmodule

// File: doc/traffic_input_conditioner.md
TRAFFIC_INPUT_CONDITIONER -- requirements
Module: traffic_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive cycles an input must differ from its clean value before the clean value changes; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock, no other clock or reset SHALL exist.
REQ-004 sensor_raw  input  1  asynchronous side-street vehicle sensor contact.
REQ-005 walk_raw  input  1  asynchronous pedestrian push-button.
REQ-006 reprogram_raw  input  1  asynchronous reprogram push-button.
REQ-007 walk_clear  input  1  synchronous one-cycle pulse from the traffic controller when the walk phase is served.
REQ-008 sensor  output  1  debounced sensor level, feeds the controller's sensor input.
REQ-009 walkRequest  output  1  latched pending pedestrian request, feeds the controller's walkRequest input.
REQ-010 reprogram  output  1  one-cycle pulse per debounced reprogram press, feeds the controller's reprogram input.

Function
REQ-011 Each raw input SHALL pass through its own two-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each channel SHALL hold a clean bit and an 8-bit counter; counter SHALL reset to 0 whenever sync2 equals clean.
REQ-013 While sync2 differs from clean, counter SHALL increment each cycle; on the cycle it would reach DEBOUNCE_CYCLES the clean bit SHALL take sync2 and the counter SHALL return to 0.
REQ-014 Latency: raw change first sampled at edge k, held stable, SHALL change clean at edge k+1+DEBOUNCE_CYCLES.
REQ-015 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave clean unchanged.
REQ-016 Counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap); with DEBOUNCE_CYCLES=1 clean SHALL follow sync2 with one cycle delay.
REQ-017 sensor SHALL equal the sensor channel clean bit directly (level, no latching).
REQ-018 reprogram SHALL be 1 for exactly one cycle, the cycle after the reprogram clean bit rises 0->1; held button SHALL produce no further pulses until released and re-pressed (clean falls then rises).
REQ-019 walkRequest SHALL set to 1 on the cycle after the walk clean bit rises 0->1 and SHALL stay 1 until walk_clear.
REQ-020 walk_clear while walkRequest=1 SHALL clear walkRequest at the next edge.
REQ-021 Simultaneous walk rising-edge detect and walk_clear SHALL leave walkRequest=1 (set wins; no request lost).
REQ-022 walk_clear while walkRequest=0 SHALL have no effect; repeated presses while pending SHALL have no further effect.
REQ-023 Walk button held across walk_clear SHALL NOT re-set walkRequest until a release and new press are debounced.

Reset
REQ-024 While reset=1 at a rising edge: all sync flops, clean bits and counters SHALL go to 0; sensor=0, walkRequest=0, reprogram=0 from the next cycle.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; an input still high after reset release SHALL be debounced afresh (full latency per REQ-014) and SHALL then produce a reprogram pulse / walk set as a new rising edge.
REQ-026 No output SHALL be X after the first reset edge.

Verification
REQ-027 DEBOUNCE_CYCLES=4, reset 1 cycle, sensor_raw 0->1 held at edge k -> sensor=1 exactly at edge k+5, stays 1; sensor_raw 1->0 -> sensor=0 at edge k'+5.
REQ-028 sensor_raw pulse 3 cycles wide, then 0 -> sensor stays 0, counter back to 0.
REQ-029 reprogram_raw held high 20 cycles -> reprogram high for exactly one cycle at edge k+6; released and re-pressed -> second single pulse.
REQ-030 walk_raw press 6 cycles -> walkRequest=1 at edge k+6 and holds; walk_clear pulse 10 cycles later -> walkRequest=0 next edge.
REQ-031 walk rising-edge detect in same cycle as walk_clear -> walkRequest remains 1.
REQ-032 reset asserted 2 cycles after sensor_raw rise, released while sensor_raw still 1 -> sensor=0 during reset, sensor=1 at release edge+5.
